multi_clock_divider: RTL

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

---
 rtl/multi_clock_divider.sv | 108 ++++++++++
 1 files changed

// File: rtl/multi_clock_divider.sv
// Bank of independent programmable clock dividers with shadowed
// settings that take effect at the next period boundary.
module multi_clock_divider #(
  parameter int CHANNELS        = 2,
  parameter int WIDTH           = 28,
  parameter int DEFAULT_DIVISOR = 2,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                load,
  input  logic [SEL_W-1:0]    channel_sel,
  input  logic [WIDTH-1:0]    divisor_in,
  input  logic [WIDTH-1:0]    high_in,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_RAW = WIDTH'(DEFAULT_DIVISOR);
  localparam logic [WIDTH-1:0] DEF_DIV = (DEF_RAW < TWO) ? TWO : DEF_RAW;
  localparam logic [WIDTH-1:0] DEF_HIGH = DEF_DIV >> 1;

  function automatic logic [WIDTH-1:0] clamp_div(
    input logic [WIDTH-1:0] d
  );
    return (d < TWO) ? TWO : d;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div_act, high_act, cnt;
    logic [WIDTH-1:0] div_pend, high_pend;
    logic             pend_valid, clk_q, tick_q;
    logic [WIDTH-1:0] div_n, high_n, cnt_n;
    logic [WIDTH-1:0] div_pend_n, high_pend_n;
    logic             pend_n, clk_n, tick_n, sel;

    assign sel = load && (channel_sel == SEL_W'(i));

    always_comb begin
      div_n       = div_act;
      high_n      = high_act;
      cnt_n       = cnt;
      div_pend_n  = div_pend;
      high_pend_n = high_pend;
      pend_n      = pend_valid;
      clk_n       = 1'b0;
      tick_n      = 1'b0;
      if (enable[i]) begin
        if (cnt >= div_act - ONE) begin
          cnt_n = '0;
          if (pend_valid) begin
            div_n  = div_pend;
            high_n = high_pend;
            pend_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
        clk_n  = cnt_n < high_n;
        tick_n = cnt_n == '0;
      end else begin
        if (pend_valid) begin
          div_n  = div_pend;
          high_n = high_pend;
          pend_n = 1'b0;
        end
        // parked on the last count so re-enable starts a fresh period
        cnt_n = div_n - ONE;
      end
      if (sel) begin
        div_pend_n  = clamp_div(divisor_in);
        high_pend_n = high_in;
        pend_n      = 1'b1;
      end
    end

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        div_act    <= DEF_DIV;
        high_act   <= DEF_HIGH;
        cnt        <= DEF_DIV - ONE;
        div_pend   <= '0;
        high_pend  <= '0;
        pend_valid <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        div_act    <= div_n;
        high_act   <= high_n;
        cnt        <= cnt_n;
        div_pend   <= div_pend_n;
        high_pend  <= high_pend_n;
        pend_valid <= pend_n;
        clk_q      <= clk_n;
        tick_q     <= tick_n;
      end
    end

    assign clock_out[i] = clk_q;
    assign tick[i]      = tick_q;
    assign pending[i]   = pend_valid;
  end

endmodule
